cdc_tx_arbiter: RTL and testbench
=================================

Name: cdc_tx_arbiter

Overview:
- Round-robin, packet-atomic arbiter that lets NUM_REQ source-domain requesters share one clock-domain-crossing channel's valid/ready input.
- It sits entirely in the source clock domain, directly in front of the CDC block's src_data/src_valid/src_ready.
- It tags each beat with the requester ID so the destination side can demultiplex.
- It holds a grant for a whole packet (until last) and enforces a maximum burst length.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per beat.
- ID_WIDTH, 2, width of out_id; must be >= clog2(NUM_REQ).
- MAX_BURST, 16, maximum beats per grant (>= 1); the counter width is clog2(MAX_BURST+1).

Ports:
- clk  input  1  single clock for the block (source clock domain of the CDC channel).
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  final beat of the packet.
- req_ready  output  NUM_REQ  beat accepted from requester i when req_valid[i] && req_ready[i].
- out_data  output  DATA_WIDTH  to CDC src_data.
- out_id  output  ID_WIDTH  index of the granted requester.
- out_last  output  1  last beat of the granted packet (natural or forced).
- out_valid  output  1  to CDC src_valid.
- out_ready  input  1  from CDC src_ready.
- grant  output  NUM_REQ  one-hot registered grant; all zero when idle.
- busy  output  1  high in the LOCKED state.
- err_burst  output  1  one-cycle pulse when a grant is force-released at MAX_BURST.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE, grant=0, beat_cnt=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - busy=0, err_burst=0, out_valid=0, req_ready=0.
  - Reset mid-packet abandons the packet with no flush. The CDC sees out_valid drop; requesters must resend.
- State machine IDLE / LOCKED:
  - In IDLE, out_valid=0 and req_ready=0 (no combinational path from req_valid to out_valid).
  - IDLE with any req_valid set: select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ. Register it into grant/out_id, clear beat_cnt, then go to LOCKED. Arbitration latency is 1 cycle.
  - IDLE with no req_valid: stay in IDLE.
  - In LOCKED with granted index g, the datapath is a combinational pass-through:
    - out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready.
    - All other req_ready bits are 0.
    - out_last=req_last[g] OR (beat_cnt==MAX_BURST-1).
    - out_id is stable for the whole grant.
- Beat accept (out_valid && out_ready): beat_cnt increments.
- Release (accepted beat with out_last=1): go to IDLE, last_grant=g, grant cleared at the next edge.
  - If req_last[g]=0 at release (forced by MAX_BURST), pulse err_burst for 1 cycle. The remaining beats of that packet re-arbitrate as a new packet.
- Gaps: req_valid[g] dropping mid-packet keeps the grant (no timeout). out_valid follows it low.
- Backpressure: out_ready=0 holds the beat. Requesters must hold data stable while valid && !ready. The arbiter adds no storage.
- Minimum idle between packets is 1 cycle (IDLE arbitration cycle). Peak throughput is packet_len/(packet_len+1).
- Fairness: a requester that is continuously requesting is granted within NUM_REQ-1 other packets.
- Requests arriving in the same cycle as release are only considered in the following IDLE cycle. No back-to-back grant without the IDLE cycle.
- Single-beat packet (req_last on first beat): LOCKED for exactly 1 accepted beat.
- MAX_BURST=1: every beat is forced last. err_burst pulses whenever req_last=0.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-beat packet (0xA0, 0xA1, 0xA2 with last), out_ready=1 -> grant=0001 one cycle later. out_data sequence A0/A1/A2, out_id=0, out_last on 3rd beat. Returns to IDLE with busy=0.
- req_valid=4'b1111 with 1-beat packets held continuously -> grant order 0,1,2,3,0. Each grant lasts 1 beat with 1 idle cycle between. out_id matches.
- Requester 2 sends 4 beats while out_ready toggles 1,0,0,1,1,0,1 -> exactly 4 accepted beats, data held during stalls. req_ready[others]=0 throughout.
- MAX_BURST=4, requester 1 sends 6 beats with last on the 6th -> out_last forced on the 4th beat and err_burst pulses once. The remaining 2 beats are granted as a new packet and err_burst stays 0.
- rst asserted on the 2nd beat of a packet from requester 3 -> next cycle out_valid=0, grant=0, busy=0. The next arbitration with all requesting grants requester 0.
- Requester 0 drops req_valid for 3 cycles mid-packet while requester 1 requests -> grant stays 0001, req_ready[1]=0, and the packet completes before requester 1 is granted.

Source files
------------

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: round-robin, packet-atomic arbiter in front of a CDC channel's valid/ready input.
// Ports:
//   clk, rst                 source-domain clock, synchronous active-high reset
//   req_valid/data/last      per-requester beat inputs (requester i data at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready                per-requester accept, only the granted requester sees out_ready
//   out_data/id/last/valid   beat towards the CDC src side, tagged with the granted requester index
//   out_ready                CDC src_ready
//   grant                    registered one-hot grant, zero when idle
//   busy                     high while a packet owns the channel
//   err_burst                one-cycle pulse after a grant was force-released at MAX_BURST
module cdc_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          err_burst
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0] gidx_q, gidx_d, last_q, last_d, sel, idx;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d, found, g_last, accept;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Data mux keyed on the registered index so out_id and out_data always agree.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gidx_q == ID_WIDTH'(i)) out_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // grant_q is zero in IDLE, which keeps every pass-through path closed there.
    assign g_last    = |(req_last & grant_q);
    assign out_valid = |(req_valid & grant_q);
    assign req_ready = grant_q & {NUM_REQ{out_ready}};
    assign out_last  = busy && (g_last || cnt_q == CW'(MAX_BURST - 1));
    assign accept    = out_valid && out_ready;
    assign busy      = (state_q == LOCKED);
    assign grant     = grant_q;
    assign out_id    = gidx_q;
    assign err_burst = err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = LOCKED;
                gidx_d  = sel;
                grant_d = NUM_REQ'(1) << sel;
                cnt_d   = '0;
            end
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (out_last) begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = gidx_q;
                // Release without the requester's own last means the burst cap cut the packet.
                err_d   = !g_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb_cdc_tx_arbiter: directed and randomized checks of cdc_tx_arbiter against a packet-level model.
module tb_cdc_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MB = 4;
    localparam int LW = IW + 1 + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_last, out_valid, out_ready, busy, err_burst;

    cdc_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_data(out_data), .out_id(out_id), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .grant(grant), .busy(busy), .err_burst(err_burst)
    );

    int errors = 0;
    int checks = 0;

    // Per-requester packet sources: {last, data} beats in FIFO order.
    logic [DW:0] mem [N][256];
    int          wp [N];
    int          rp [N];
    logic [N-1:0] hold = '0;

    // Packet-level reference: who owns the channel, beats sent in this grant, previous owner.
    int   m_owner = -1;
    int   m_cnt   = 0;
    int   m_lastg = N - 1;
    logic m_err   = 1'b0;

    logic [LW-1:0] log_q[$];
    int            err_pulses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[r][wp[r] % 256] = {i == n - 1, base + DW'(i)};
            wp[r]++;
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rp[i] < wp[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic [DW:0] b;
            b = (rp[i] < wp[i]) ? mem[i][rp[i] % 256] : {1'b0, DW'(32'hDEAD0000 + i)};
            req_valid[i]             = (rp[i] < wp[i]) && !hold[i];
            req_last[i]              = b[DW];
            req_data[i*DW +: DW]     = b[DW-1:0];
        end
    endtask

    task automatic cycle();
        logic [N-1:0] eg;
        logic ev, el, acc;
        int k, idx;
        drive();
        #3;
        eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        ev = (m_owner >= 0) && req_valid[m_owner];
        el = (m_owner >= 0) && (req_last[m_owner] || m_cnt == MB - 1);
        chk("grant", 64'(grant), 64'(eg));
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        chk("err_burst", 64'(err_burst), 64'(m_err));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("req_ready", 64'(req_ready), 64'(out_ready ? eg : '0));
        if (m_owner >= 0) chk("out_id", 64'(out_id), 64'(m_owner));
        if (ev) begin
            chk("out_data", 64'(out_data), 64'(req_data[m_owner*DW +: DW]));
            chk("out_last", 64'(out_last), 64'(el));
        end
        if (out_valid && out_ready) log_q.push_back({out_id, out_last, out_data});
        if (err_burst) err_pulses++;
        acc = ev && out_ready;
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_lastg = N - 1; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_owner < 0) begin
                for (k = 1; k <= N; k++) begin
                    idx = (m_lastg + k) % N;
                    if (m_owner < 0 && req_valid[idx]) m_owner = idx;
                end
                m_cnt = 0;
            end else if (acc) begin
                rp[m_owner]++;
                m_cnt++;
                if (el) begin
                    m_err   = !req_last[m_owner];
                    m_lastg = m_owner;
                    m_owner = -1;
                end
            end
        end
        #1;
    endtask

    task automatic run_until_idle(input int max, input string tag);
        int n = 0;
        while ((pending() || m_owner >= 0) && n < max) begin
            cycle();
            n++;
        end
        chk(tag, 64'(n < max), 64'd1);
    endtask

    function automatic logic [LW-1:0] entry(input int i);
        return (i < log_q.size()) ? log_q[i] : 'x;
    endfunction

    function automatic logic [IW-1:0] id_of(input int i);
        logic [LW-1:0] e;
        e = entry(i);
        return e[DW+1 +: IW];
    endfunction

    initial begin
        logic [6:0] pat;
        for (int i = 0; i < N; i++) begin wp[i] = 0; rp[i] = 0; end
        out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        drive();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_err", 64'(err_burst), 64'd0);
        rst = 1'b0;

        // Three-beat packet from requester 0
        log_q.delete();
        push(0, 3, 32'hA0);
        run_until_idle(20, "t1_timeout");
        chk("t1_count", 64'(log_q.size()), 64'd3);
        chk("t1_b0", 64'(entry(0)), 64'({2'd0, 1'b0, 32'hA0}));
        chk("t1_b1", 64'(entry(1)), 64'({2'd0, 1'b0, 32'hA1}));
        chk("t1_b2", 64'(entry(2)), 64'({2'd0, 1'b1, 32'hA2}));
        chk("t1_busy", 64'(busy), 64'd0);

        // All requesters with single-beat packets: round-robin order from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        log_q.delete();
        for (int r = 0; r < N; r++) begin push(r, 1, 32'h10 * r); push(r, 1, 32'h10 * r + 32'h100); end
        run_until_idle(40, "t2_timeout");
        chk("t2_id0", 64'(id_of(0)), 64'd0);
        chk("t2_id1", 64'(id_of(1)), 64'd1);
        chk("t2_id2", 64'(id_of(2)), 64'd2);
        chk("t2_id3", 64'(id_of(3)), 64'd3);
        chk("t2_id4", 64'(id_of(4)), 64'd0);
        chk("t2_count", 64'(log_q.size()), 64'd8);

        // Requester 2 under toggling backpressure
        log_q.delete();
        err_pulses = 0;
        push(2, 4, 32'hC0);
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin out_ready = pat[i]; cycle(); end
        out_ready = 1'b1;
        run_until_idle(20, "t3_timeout");
        chk("t3_count", 64'(log_q.size()), 64'd4);
        chk("t3_b0", 64'(entry(0)), 64'({2'd2, 1'b0, 32'hC0}));
        chk("t3_b1", 64'(entry(1)), 64'({2'd2, 1'b0, 32'hC1}));
        chk("t3_b2", 64'(entry(2)), 64'({2'd2, 1'b0, 32'hC2}));
        chk("t3_b3", 64'(entry(3)), 64'({2'd2, 1'b1, 32'hC3}));
        chk("t3_no_err", 64'(err_pulses), 64'd0);

        // Six-beat packet from requester 1 cut at MAX_BURST=4
        log_q.delete();
        err_pulses = 0;
        push(1, 6, 32'hB0);
        run_until_idle(30, "t4_timeout");
        chk("t4_count", 64'(log_q.size()), 64'd6);
        chk("t4_b3_forced", 64'(entry(3)), 64'({2'd1, 1'b1, 32'hB3}));
        chk("t4_b4", 64'(entry(4)), 64'({2'd1, 1'b0, 32'hB4}));
        chk("t4_b5", 64'(entry(5)), 64'({2'd1, 1'b1, 32'hB5}));
        chk("t4_err_once", 64'(err_pulses), 64'd1);

        // Reset on the second beat of a packet from requester 3
        push(3, 4, 32'hD0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) rp[i] = wp[i];
        drive();
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        log_q.delete();
        for (int r = 0; r < N; r++) push(r, 1, 32'h50 + r);
        run_until_idle(20, "t5_timeout");
        chk("t5_first_id", 64'(id_of(0)), 64'd0);

        // Requester 0 gaps mid-packet while requester 1 waits
        log_q.delete();
        push(0, 4, 32'hE0);
        push(1, 2, 32'hF0);
        cycle();
        cycle();
        hold[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_grant_held", 64'(grant), 64'b0001);
            chk("t6_rr1", 64'(req_ready[1]), 64'd0);
        end
        hold[0] = 1'b0;
        run_until_idle(30, "t6_timeout");
        chk("t6_count", 64'(log_q.size()), 64'd6);
        chk("t6_id3", 64'(id_of(3)), 64'd0);
        chk("t6_last3", 64'(entry(3)), 64'({2'd0, 1'b1, 32'hE3}));
        chk("t6_id4", 64'(id_of(4)), 64'd1);

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (wp[r] - rp[r] < 20) push(r, $urandom_range(1, 6), DW'($urandom));
            end
            hold      = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        hold      = '0;
        out_ready = 1'b1;
        run_until_idle(600, "rand_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
